// File: rtl/score_argmax.sv
// Signed argmax over a latched packed score vector, scanning one class per cycle.
// Result and done pulse land NUM_CLASSES-1 edges after the accepting edge; start is ignored while busy.
module score_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_WIDTH = 26,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                               clk,
    input  logic                               GlobalReset,
    input  logic [NUM_CLASSES*SCORE_WIDTH-1:0] value,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [IDX_WIDTH-1:0]               class_idx,
    output logic [SCORE_WIDTH-1:0]             max_score
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                             state_q, state_d;
    logic [NUM_CLASSES*SCORE_WIDTH-1:0] vec_q, vec_d;
    logic [SCORE_WIDTH-1:0]             work_max_q, work_max_d;
    logic [IDX_WIDTH-1:0]               work_idx_q, work_idx_d;
    logic [IDX_WIDTH-1:0]               cnt_q, cnt_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic [IDX_WIDTH-1:0]               class_idx_q, class_idx_d;
    logic [SCORE_WIDTH-1:0]             max_score_q, max_score_d;

    logic [SCORE_WIDTH-1:0]             cur_score;
    logic [SCORE_WIDTH-1:0]             cand_max;
    logic [IDX_WIDTH-1:0]               cand_idx;

    always_comb begin
        cur_score = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (cnt_q == IDX_WIDTH'(k)) begin
                cur_score = vec_q[k*SCORE_WIDTH +: SCORE_WIDTH];
            end
        end
    end

    // Strict greater-than: on a tie the earlier (lower) index is kept.
    always_comb begin
        cand_max = work_max_q;
        cand_idx = work_idx_q;
        if ($signed(cur_score) > $signed(work_max_q)) begin
            cand_max = cur_score;
            cand_idx = cnt_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        work_max_d  = work_max_q;
        work_idx_d  = work_idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d = value;
                    if (NUM_CLASSES == 1) begin
                        class_idx_d = '0;
                        max_score_d = value[SCORE_WIDTH-1:0];
                        done_d      = 1'b1;
                    end else begin
                        work_max_d = value[SCORE_WIDTH-1:0];
                        work_idx_d = '0;
                        cnt_d      = IDX_WIDTH'(1);
                        busy_d     = 1'b1;
                        state_d    = SCAN;
                    end
                end
            end
            SCAN: begin
                work_max_d = cand_max;
                work_idx_d = cand_idx;
                cnt_d      = cnt_q + IDX_WIDTH'(1);
                if (cnt_q == LAST_IDX) begin
                    class_idx_d = cand_idx;
                    max_score_d = cand_max;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            work_max_q  <= '0;
            work_idx_q  <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            class_idx_q <= '0;
            max_score_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            work_max_q  <= work_max_d;
            work_idx_q  <= work_idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign class_idx = class_idx_q;
    assign max_score = max_score_q;

endmodule

// File: doc/score_argmax.md
Name: score_argmax

Overview:
- Consumes the 260-bit packed score vector produced by the vector-matrix product stage and reports the winning digit class.
- The input is 10 classes × 26-bit two's-complement 8.18 fixed point.
- The block latches the vector on a start strobe, scans one score per cycle with a signed compare, and emits the class index and winning score with a one-cycle done pulse.
- It sits directly downstream of the vector-matrix product, at the classifier output.

Parameters:
- NUM_CLASSES, 10, number of scores in the packed vector.
- SCORE_WIDTH, 26, bits per score (8 integer . 18 fraction, signed).
- IDX_WIDTH, 4, width of the class index; must satisfy 2^IDX_WIDTH >= NUM_CLASSES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- GlobalReset  input  1  synchronous, active-high reset.
- value  input  NUM_CLASSES*SCORE_WIDTH (260)  packed scores; class k occupies value[k*SCORE_WIDTH +: SCORE_WIDTH].
- start  input  1  request to classify the current value; sampled only in IDLE.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when class_idx/max_score update.
- class_idx  output  IDX_WIDTH  index of the maximum score.
- max_score  output  SCORE_WIDTH  value of the maximum score.

Behaviour:
- Reset: when GlobalReset=1 at a rising edge:
  - state=IDLE; busy=0, done=0, class_idx=0, max_score=0.
  - Internal latch, counter and working registers are cleared.
  - Reset has priority over start and over an in-progress scan.
- FSM has two states, IDLE and SCAN.
- IDLE:
  - start=1 at edge E0: latch all of value into an internal register (later changes on value are ignored).
  - Set work_max=score0, work_idx=0, cnt=1, busy=1, state=SCAN.
  - start=0: remain in IDLE.
- SCAN, at each edge:
  - If signed(score[cnt]) > signed(work_max), then work_max=score[cnt] and work_idx=cnt.
  - Compare is strictly greater, so ties keep the lower index.
  - cnt increments by 1.
  - When cnt==NUM_CLASSES-1 is processed: class_idx and max_score take the final result (including that last compare), done=1, busy=0, state=IDLE.
- Latency: with start sampled at E0, done is high in the cycle following edge E0+NUM_CLASSES-1 (E0+9 by default), for exactly one cycle.
- Throughput: one classification per NUM_CLASSES cycles.
  - start may be asserted in the cycle done is high; it is accepted at the next edge, so there is no dead cycle.
- class_idx/max_score hold their last result until the next completion; they do not change during SCAN.
- done is 0 in every cycle except the completion cycle.
- start while busy=1 is ignored: no restart, no queuing.
- start held high continuously gives back-to-back scans, each re-latching value.
- GlobalReset during SCAN aborts the scan: outputs return to reset values and no done pulse is produced for the aborted scan.
- NUM_CLASSES=1: scan completes at E0 itself; done follows E0.
- Arithmetic:
  - Pure signed comparison at SCORE_WIDTH; no extension or rounding.
  - The most negative code (0x2000000, -128.0) is a valid score.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- All ten scores = 100.0 (0x1900000), start one cycle → done exactly 10 cycles after the start edge, class_idx=0, max_score=0x1900000; busy high for 9 cycles.
- Scores 1.0·k for k≠7 (0x40000·k), score7=50.0 (0x0C80000) → class_idx=7, max_score=0x0C80000.
- All scores negative: scores 0–8 = 0x2000000 (-128.0), score9=0x3FC0000 (-1.0) → class_idx=9, max_score=0x3FC0000. This checks signed rather than unsigned compare.
- Run scenario 2, then change value and pulse start at cycle 4 of the scan → ignored; result is still class 7. Then start in the done cycle with score3 max → second done 10 cycles later, class_idx=3.
- Start a scan, assert GlobalReset on cycle 5 → next cycle busy=0, done=0, class_idx=0, max_score=0, and no done pulse follows. A subsequent start completes normally.
- Scores 4 and 8 both 20.0, all others 0 → class_idx=4 (tie keeps lowest index).
